mux_rr_arbiter_4x1: RTL and testbench
=====================================

Name: mux_rr_arbiter_4x1

Overview:
- Round-robin arbiter that shares one 4:1 word-wide mux/output channel among four requesters.
- Each requester presents a valid/ready stream. The arbiter picks one, drives the mux select, and registers the chosen word into a single-entry output stage with its own valid/ready handshake.
- Sits between four producer blocks and one shared consumer (bus port, FIFO write side).

Parameters:
- WIDTH, 32, data width of each input word and of out_data.
- CNT_W, 16, width of each grant counter (used only with ARB_STATS_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  4  bit i = requester i has a word on in_data_i.
- in_ready  output  4  bit i = word on in_data_i is accepted this cycle; at most one bit set.
- in_data0  input  WIDTH  requester 0 word.
- in_data1  input  WIDTH  requester 1 word.
- in_data2  input  WIDTH  requester 2 word.
- in_data3  input  WIDTH  requester 3 word.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  2  index of the requester that supplied out_data.
- grant_cnt  output  4*CNT_W  packed per-requester grant counters; present only with ARB_STATS_EN. Counter i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset is synchronous: clk and rst only, rst active-high. On any rising edge with rst=1:
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0, grant counters=0.
  - A word held at reset is discarded.
  - in_ready=0 combinationally while rst=1.
- Output stage is a two-state FSM:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = EMPTY, or FULL with out_ready=1 (pass-through; full throughput, one word per cycle).
- Grant (combinational, same cycle):
  - If can_load and in_valid!=0, grant the first index with in_valid set, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
  - in_ready[g]=1; all other bits 0.
  - If !can_load or in_valid==0, in_ready=0.
- Transfer on requester i occurs when in_valid[i] & in_ready[i] at a clock edge.
- On a transfer edge:
  - out_data <= in_data_g via internal 4:1 selection.
  - out_sel <= g; out_valid <= 1; ptr <= (g+1) mod 4 (2-bit wrap, 3 -> 0).
- Edge with out_valid & out_ready and no new grant: out_valid <= 0. out_data and out_sel hold their last values.
- FULL & !out_ready: out_data, out_sel and out_valid hold, and in_ready=0 (backpressure).
- Pointer advances only on a grant. An idle cycle leaves ptr unchanged.
- Latency: one cycle from accepted input to out_valid.
- Fairness: a requester with continuous in_valid waits at most 3 grants.
- Requesters must hold in_valid and data until accepted. The arbiter does not depend on this, because grant is recomputed every cycle.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Port grant_cnt exists; four CNT_W-bit counters.
  - Counter i increments on each transfer from requester i.
  - Each counter saturates at all-ones; no wrap.
  - Cleared by rst.
- Undefined: no grant_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset/idle: hold rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. After rst=0 with in_valid=0 -> out_valid stays 0.
- Single requester: in_valid=4'b0100, in_data2=32'hA5A5_0002, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=32'hA5A5_0002, out_sel=2; ptr becomes 3.
- Round-robin rotation: all four valid continuously, out_ready=1, starting after reset -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles. One word per cycle; in_ready one-hot every cycle.
- Backpressure:
  - All valid, out_ready=0 after the first grant -> out_valid=1, out_sel=0 held, in_ready=0 for 5 cycles.
  - Raise out_ready -> next out_sel=1 and no word is lost.
- Sparse requests and pointer wrap: grant requester 3, then in_valid=4'b1001 -> next grant is 0 (wrap, ptr=0). Then grant 3; requester 1 becomes valid later and is granted in its turn.
- Mid-operation reset plus stats (ARB_STATS_EN):
  - Run 6 grants: counters = 2,2,1,1.
  - Saturation: force CNT_W=2 and give requester 0 five grants -> counter0 stays 3.
  - Assert rst while FULL -> out_valid=0 and all counters=0 the next cycle.

Source files
------------

// File: rtl/mux_rr_arbiter_4x1.sv
// Round-robin 4:1 arbiter/mux feeding a one-entry registered output stage; ARB_STATS_EN adds per-requester grant counters.
// One cycle from accepted input to out_valid, one word per cycle; in_ready stays low while the output is full and out_ready is low.
module mux_rr_arbiter_4x1 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
`ifdef ARB_STATS_EN
    ,
    output logic [4*CNT_W-1:0] grant_cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;
    logic [1:0]       r_ptr;

    logic             w_can_load;
    logic             w_found;
    logic [1:0]       w_gnt;
    logic [1:0]       w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux;

    assign w_can_load = (r_state == ST_EMPTY) || out_ready;

    // Scan from the farthest offset down so the one closest to ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = 2'd0;
        w_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (in_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_xfer = w_can_load && w_found && !rst;

    always_comb begin
        in_ready = 4'b0000;
        if (w_xfer) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_mux = in_data0;
        case (w_gnt)
            2'd0: w_mux = in_data0;
            2'd1: w_mux = in_data1;
            2'd2: w_mux = in_data2;
            2'd3: w_mux = in_data3;
            default: w_mux = in_data0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_out_data <= '0;
            r_out_sel  <= 2'd0;
            r_ptr      <= 2'd0;
        end else if (w_xfer) begin
            r_state    <= ST_FULL;
            r_out_data <= w_mux;
            r_out_sel  <= w_gnt;
            r_ptr      <= w_gnt + 2'd1;
        end else if ((r_state == ST_FULL) && out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [4];

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (w_xfer && (w_gnt == 2'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter_4x1.sv
// Bench for mux_rr_arbiter_4x1: directed vector table, stats sequence, then randomized run against a reference model.
module tb_mux_rr_arbiter_4x1;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] in_data [4];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
`ifdef ARB_STATS_EN
    logic [4*CNT_W-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    mux_rr_arbiter_4x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data[0]), .in_data1(in_data[1]),
        .in_data2(in_data[2]), .in_data3(in_data[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
`ifdef ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [1:0]  sel;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [27];

    // Reference model: spec-level state of the output slot and rotation pointer.
    bit          m_full;
    logic [31:0] m_dat;
    int          m_sel;
    int          m_ptr;
    int          m_cnt [4];

    function automatic int model_grant(input logic [3:0] iv, input logic ordy, input logic r);
        if (r) return -1;
        if (m_full && !ordy) return -1;
        for (int k = 0; k < 4; k++) begin
            if (iv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input int g, input logic ordy);
        if (r) begin
            m_full = 0; m_dat = '0; m_sel = 0; m_ptr = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (g >= 0) begin
            m_dat = in_data[g]; m_sel = g; m_full = 1; m_ptr = (g + 1) % 4;
            if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] iv, input logic ordy);
        rst = r; in_valid = iv; out_ready = ordy;
    endtask

    task automatic check_stats(input string name, input int c0, input int c1, input int c2, input int c3);
`ifdef ARB_STATS_EN
        logic [4*CNT_W-1:0] e;
        e = {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
        chk(name, 64'(grant_cnt), 64'(e));
`endif
    endtask

    initial begin
        int g;
        logic [4*CNT_W-1:0] e;
        logic [3:0] iv_r;
        logic ordy_r;
        logic rst_r;

        for (int i = 0; i < 4; i++) in_data[i] = 32'hA5A5_0000 + 32'(i);
        drive(1'b1, 4'h0, 1'b1);
        @(posedge clk); #1;

        //           rst   iv     ordy  ir     ov    sel   dat
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[3]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hA5A5_0002};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 32'hA5A5_0002};
        tbl[5]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA5A5_0001};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hA5A5_0002};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA5A5_0003};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA5A5_0001};
        tbl[12] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[13] = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[14] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[15] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[16] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[17] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[18] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[19] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA5A5_0001};
        tbl[20] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA5A5_0003};
        tbl[21] = '{1'b0, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA5A5_0000};
        tbl[22] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA5A5_0003};
        tbl[23] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd3, 32'hA5A5_0003};
        tbl[24] = '{1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA5A5_0001};
        tbl[25] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA5A5_0003};
        tbl[26] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA5A5_0001};

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("vec%0d out_sel", i), 64'(out_sel), 64'(tbl[i].sel));
            chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tbl[i].dat));
        end
        check_stats("stats after table", 2, 3, 0, 3);

        // Six back-to-back grants, then reset while the output is full.
        drive(1'b1, 4'hF, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 4'hF, 1'b1);
        repeat (6) begin @(posedge clk); #1; end
        chk("six grants out_valid", 64'(out_valid), 64'd1);
        check_stats("six grants counters", 2, 2, 1, 1);
        drive(1'b1, 4'hF, 1'b0);
        @(posedge clk); #1;
        chk("mid reset out_valid", 64'(out_valid), 64'd0);
        chk("mid reset out_data", 64'(out_data), 64'd0);
        check_stats("mid reset counters", 0, 0, 0, 0);

        model_edge(1'b1, -1, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst_r  = ($urandom_range(0, 199) == 0);
            iv_r   = 4'($urandom);
            ordy_r = ($urandom_range(0, 3) != 0);
            drive(rst_r, iv_r, ordy_r);
            for (int i = 0; i < 4; i++) in_data[i] = $urandom;
            @(negedge clk);
            g = model_grant(iv_r, ordy_r, rst_r);
            chk("rand in_ready", 64'(in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            model_edge(rst_r, g, ordy_r);
            @(posedge clk); #1;
            chk("rand out_valid", 64'(out_valid), 64'(m_full));
            chk("rand out_sel", 64'(out_sel), 64'(m_sel));
            chk("rand out_data", 64'(out_data), 64'(m_dat));
`ifdef ARB_STATS_EN
            for (int i = 0; i < 4; i++) e[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
            chk("rand grant_cnt", 64'(grant_cnt), 64'(e));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
